mcpu_ram_arbiter: RTL and testbench
===================================

MCPU_RAM_ARBITER -- requirements
Module: mcpu_ram_arbiter

Interface
REQ-001 The block SHALL have a parameter WORD_SIZE, default 32, giving the data word width.
REQ-002 The block SHALL have a parameter ADDR_WIDTH, default 8, giving the RAM address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i_req  in  1  instruction-fetch read request; held high until i_ack.
REQ-007 i_addr  in  ADDR_WIDTH  instruction-fetch address.
REQ-008 i_ack  out  1  one-cycle completion pulse for the instruction port.
REQ-009 i_rdata  out  WORD_SIZE  instruction word returned, valid while i_ack is high.
REQ-010 d_req  in  1  data-port request; held high until d_ack.
REQ-011 d_we  in  1  data-port direction: 1 write, 0 read.
REQ-012 d_addr  in  ADDR_WIDTH  data-port address.
REQ-013 d_wdata  in  WORD_SIZE  data-port write word.
REQ-014 d_ack  out  1  one-cycle completion pulse for the data port.
REQ-015 d_rdata  out  WORD_SIZE  data word returned, valid while d_ack is high after a read.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_re  out  1  RAM read enable.
REQ-018 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-019 ram_wdata  out  WORD_SIZE  RAM write word.
REQ-020 ram_rdata  in  WORD_SIZE  RAM read data, combinational from ram_addr while ram_re is high.
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have three states:
- IDLE: accepts requests.
- ACCESS: drives the RAM for exactly one cycle.
- RESP: pulses ack for exactly one cycle.
REQ-023 IDLE behaviour:
- If any req is high, the block SHALL select a winner and latch its address, direction and write data.
- It SHALL then move to ACCESS; otherwise it stays in IDLE.
REQ-024 Arbitration:
- A sole requester wins.
- If i_req and d_req are both high, the port that did not win the previous grant wins (round-robin), tracked by a last_grant register.
REQ-025 The instruction port SHALL only ever read; the block SHALL never assert ram_we for an instruction grant.
REQ-026 ACCESS behaviour:
- ram_addr SHALL equal the latched address.
- ram_re=1 for a read, or ram_we=1 with ram_wdata = latched word for a write.
- Read data SHALL be captured from ram_rdata into the winner's rdata register at the end of the cycle.
- The FSM then moves to RESP.
REQ-027 RESP behaviour: the winner's ack SHALL be high for exactly this cycle, and the FSM SHALL return to IDLE.
REQ-028 Latency and throughput:
- A request seen in IDLE at cycle T SHALL produce the RAM access at T+1, ack at T+2, and acceptance of a new request at T+3.
- Throughput SHALL be one transaction per 3 cycles.
REQ-029 ram_we and ram_re SHALL be 0 in IDLE and RESP; ram_we and ram_re SHALL never be high together.
REQ-030 i_ack and d_ack SHALL never be high in the same cycle.
REQ-031 Each rdata output SHALL hold its last read value until the next read for that port; a data write SHALL leave d_rdata unchanged.
REQ-032 Request handling after acceptance:
- Deasserting req after acceptance SHALL NOT abort the transaction; ack is still issued.
- A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-033 Changes to addr, d_we or d_wdata after acceptance SHALL have no effect on the transaction in progress.

Reset
REQ-034 On reset the block SHALL set:
- state = IDLE;
- i_ack, d_ack, ram_we, ram_re and busy = 0;
- i_rdata, d_rdata, ram_addr and ram_wdata = 0;
- last_grant = data, so the instruction port wins the first contention.
REQ-035 Reset mid-transaction SHALL abort it without any ack. Because ram_we/ram_re are decoded from state, a reset asserted during ACCESS takes effect at the next edge and SHALL NOT suppress that cycle's RAM strobe.

Verification
REQ-036 Data write then read: d_req, d_we=1, d_addr=0x05, d_wdata=0xDEADBEEF -> ram_we=1 and ram_addr=0x05 at T+1, d_ack at T+2; then a read of 0x05 -> d_rdata=0xDEADBEEF with d_ack at T+2.
REQ-037 Contention after reset: i_req (i_addr=0x10) and d_req (d_addr=0x20) raised together and held -> instruction granted first (i_ack at T+2), data second (d_ack at T+5); ram_addr=0x10 then 0x20.
REQ-038 Sustained contention: both requesters continuously re-requesting for 12 cycles -> acks alternate i, d, i, d; no cycle has both acks high.
REQ-039 Fill and check: write random words to all 2^ADDR_WIDTH addresses via the data port, then read every address via both ports -> i_rdata and d_rdata match the stored words at every address.
REQ-040 Reset in ACCESS: reset asserted during the ACCESS cycle of a read -> no ack issued, busy=0 and all strobes 0 the next cycle, d_rdata=0.

Source files
------------

// File: rtl/mcpu_ram_arbiter_if.sv
// Bus bundle between the two CPU request ports, the arbiter and a single RAM.
//   slave  : arbiter side (takes requests and ram_rdata; drives acks, rdata, RAM strobes, busy)
//   master : environment side (CPU ports plus RAM model)
interface mcpu_ram_arbiter_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    // Instruction-fetch port (read only)
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [WORD_SIZE-1:0]  i_rdata;

    // Data port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [WORD_SIZE-1:0]  d_wdata;
    logic                  d_ack;
    logic [WORD_SIZE-1:0]  d_rdata;

    // RAM side
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_SIZE-1:0]  ram_wdata;
    logic [WORD_SIZE-1:0]  ram_rdata;

    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output ram_we, ram_re, ram_addr, ram_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  ram_we, ram_re, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mcpu_ram_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of one RAM.
// Each transaction takes IDLE -> ACCESS -> RESP, i.e. one transaction per 3 cycles.
// Ports:
//   clk   : rising-edge clock for all state
//   reset : synchronous active-high reset
//   bus   : mcpu_ram_arbiter_if.slave (request ports, RAM strobes, busy)
// All outputs are registered.
module mcpu_ram_arbiter #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mcpu_ram_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   last_d_q;   // 1: data port won the previous grant
    logic                   gnt_d_q;    // winner of the transaction in flight
    logic                   i_ack_q;
    logic                   d_ack_q;
    logic [WORD_SIZE-1:0]   i_rdata_q;
    logic [WORD_SIZE-1:0]   d_rdata_q;
    logic                   ram_we_q;
    logic                   ram_re_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [WORD_SIZE-1:0]   ram_wdata_q;
    logic                   busy_q;

    // Grant for the next acceptance: sole requester wins, otherwise the port
    // that lost last time.
    logic pick_d_d;
    assign pick_d_d = bus.d_req && (!bus.i_req || !last_d_q);

    // Transaction FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b1;
            gnt_d_q     <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state_q  <= S_ACCESS;
                        busy_q   <= 1'b1;
                        gnt_d_q  <= pick_d_d;
                        last_d_q <= pick_d_d;
                        if (pick_d_d) begin
                            ram_addr_q <= bus.d_addr;
                            ram_we_q   <= bus.d_we;
                            ram_re_q   <= !bus.d_we;
                            if (bus.d_we) begin
                                ram_wdata_q <= bus.d_wdata;
                            end
                        end else begin
                            // Instruction port is read-only
                            ram_addr_q <= bus.i_addr;
                            ram_we_q   <= 1'b0;
                            ram_re_q   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    state_q  <= S_RESP;
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    // RAM read data is combinational, capture it as the strobe ends
                    if (ram_re_q) begin
                        if (gnt_d_q) begin
                            d_rdata_q <= bus.ram_rdata;
                        end else begin
                            i_rdata_q <= bus.ram_rdata;
                        end
                    end
                    if (gnt_d_q) begin
                        d_ack_q <= 1'b1;
                    end else begin
                        i_ack_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    i_ack_q  <= 1'b0;
                    d_ack_q  <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Self-checking bench for mcpu_ram_arbiter: RAM model plus a scoreboard of
// expected transactions that is popped as acks appear.
module tb_mcpu_ram_arbiter;

    localparam int unsigned WS    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcpu_ram_arbiter_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

    mcpu_ram_arbiter #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: combinational read while ram_re, write on the clock edge
    logic [WS-1:0] mem [DEPTH];
    assign bus.ram_rdata = bus.ram_re ? mem[bus.ram_addr] : '0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
        int            cyc;   // expected ack cycle, counted from the request cycle
    } exp_t;

    exp_t          sbq[$];
    logic [WS-1:0] gold [DEPTH];
    logic [WS-1:0] last_d;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit we, input logic [AW-1:0] a,
                        input logic [WS-1:0] w, input int cyc);
        exp_t e;
        if (we) gold[a] = w;
        e.is_d = is_d;
        e.we   = we;
        e.addr = a;
        e.data = we ? w : gold[a];
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    // Watch n transactions complete; hold keeps both reqs high throughout.
    task automatic collect(input int n, input bit hold, input bit scramble);
        int   got = 0;
        int   cyc = 0;
        exp_t e;
        while (got < n && cyc < 3 * n + 8) begin
            @(negedge clk);
            if (bus.ram_we && bus.ram_re) chk("strobe_excl", 64'(1), 64'(0));
            if (bus.i_ack && bus.d_ack)   chk("ack_excl", 64'(1), 64'(0));
            if (bus.ram_we || bus.ram_re) begin
                if (sbq.size() == 0) chk("spurious_strobe", 64'(1), 64'(0));
                else begin
                    chk("ram_addr", 64'(bus.ram_addr), 64'(sbq[0].addr));
                    chk("ram_we", 64'(bus.ram_we), 64'(sbq[0].we));
                    chk("strobe_cycle", 64'(cyc), 64'(sbq[0].cyc - 1));
                    chk("busy_access", 64'(bus.busy), 64'(1));
                    if (sbq[0].we) chk("ram_wdata", 64'(bus.ram_wdata), 64'(sbq[0].data));
                end
            end
            if (scramble && cyc == 1) begin
                bus.d_addr  = AW'($urandom);
                bus.d_wdata = $urandom;
                bus.d_we    = 1'($urandom);
                bus.i_addr  = AW'($urandom);
            end
            if (bus.i_ack || bus.d_ack) begin
                if (sbq.size() == 0) chk("spurious_ack", 64'(1), 64'(0));
                else begin
                    e = sbq.pop_front();
                    chk("ack_port", 64'(bus.d_ack), 64'(e.is_d));
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_resp", 64'(bus.busy), 64'(1));
                    if (e.is_d) begin
                        if (e.we) chk("d_rdata_hold", 64'(bus.d_rdata), 64'(last_d));
                        else begin
                            chk("d_rdata", 64'(bus.d_rdata), 64'(e.data));
                            last_d = e.data;
                        end
                    end else begin
                        chk("i_rdata", 64'(bus.i_rdata), 64'(e.data));
                    end
                    if (!hold) begin
                        if (e.is_d) bus.d_req = 1'b0;
                        else        bus.i_req = 1'b0;
                    end
                    got++;
                end
            end
            cyc++;
        end
        if (got < n) chk("timeout", 64'(got), 64'(n));
        if (hold) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
    endtask

    task automatic txn(input bit is_d, input bit we, input logic [AW-1:0] a, input logic [WS-1:0] w);
        @(posedge clk); #1;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a;
        end
        push(is_d, we, a, w, 2);
        collect(1, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_quiet", 64'({bus.i_ack, bus.d_ack, bus.ram_we, bus.ram_re, bus.busy}), 64'(0));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_d = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        last_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ack", 64'(bus.i_ack), 64'(0));
        chk("rst_d_ack", 64'(bus.d_ack), 64'(0));
        chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
        chk("rst_ram_re", 64'(bus.ram_re), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_i_rdata", 64'(bus.i_rdata), 64'(0));
        chk("rst_d_rdata", 64'(bus.d_rdata), 64'(0));
        chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
        chk("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Data write then read back
        txn(1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 8'h05, '0);

        // Seed the contention addresses, then start again from reset
        txn(1'b1, 1'b1, 8'h10, 32'h1111_0010);
        txn(1'b1, 1'b1, 8'h20, 32'h2222_0020);
        do_reset();

        // Contention after reset: instruction first, data three cycles later
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
        push(1'b0, 1'b0, 8'h10, '0, 2);
        push(1'b1, 1'b0, 8'h20, '0, 5);
        collect(2, 1'b0, 1'b0);

        // Sustained contention: both requesting continuously for 12 cycles
        @(posedge clk); #1;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        push(1'b0, 1'b0, 8'h10, '0, 2);
        push(1'b1, 1'b0, 8'h20, '0, 5);
        push(1'b0, 1'b0, 8'h10, '0, 8);
        push(1'b1, 1'b0, 8'h20, '0, 11);
        collect(4, 1'b1, 1'b0);
        idle(3);

        // Reset during the ACCESS cycle of a data read
        txn(1'b1, 1'b0, 8'h05, '0);
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h05;
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc_ram_re", 64'(bus.ram_re), 64'(1));
        reset = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("rst_acc_ram_re_after", 64'(bus.ram_re), 64'(0));
        chk("rst_acc_ram_we_after", 64'(bus.ram_we), 64'(0));
        chk("rst_acc_busy", 64'(bus.busy), 64'(0));
        chk("rst_acc_acks", 64'({bus.i_ack, bus.d_ack}), 64'(0));
        chk("rst_acc_d_rdata", 64'(bus.d_rdata), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        last_d = '0;
        idle(4);

        // Fill every address through the data port, read back through both ports
        for (int a = 0; a < int'(DEPTH); a++) txn(1'b1, 1'b1, AW'(a), $urandom);
        for (int a = 0; a < int'(DEPTH); a++) begin
            txn(1'b0, 1'b0, AW'(a), '0);
            txn(1'b1, 1'b0, AW'(a), '0);
        end
        idle(3);
        if (sbq.size() != 0) chk("sb_leftover", 64'(sbq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
